// File: rtl/core_pkg.sv
// Shared core definitions: run-sequencer state encoding and program geometry.
// Also used by the branch-target lookup and the instruction ROM, so the
// program length and address width are defined in exactly one place.
package core_pkg;

  // Run sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  // Fetch address width
  localparam int PC_W = 8;

  // Program end address; reaching it is a clean halt
  localparam int PROG_LEN = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones instead of
// wrapping, so a runaway program cannot make the retired count look small.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = &r_q;

  // Count on inc until all-ones; clr wins over inc, reset wins over both
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && !w_at_max) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and start/done run sequencer for the single-issue core.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | after reset; waiting for start, all other inputs ignored
//   RUN    | fetching; one instruction retires per non-stalled cycle
//   HALTED | run finished (halt, end address, or out-of-range branch);
//          | outputs frozen until the next start
//
// The clean-halt and out-of-range decisions compare against PROG_LEN as a
// D-bit unsigned value. A branch exactly to PROG_LEN is treated like running
// off the end of the program (clean halt), only beyond it is a fault.
module pc_sequencer #(
  parameter int D        = core_pkg::PC_W,
  parameter int PROG_LEN = core_pkg::PROG_LEN,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             branch,
  input  logic [D-1:0]     target,
  input  logic             halt_req,
  output logic [D-1:0]     prog_ctr,
  output logic             running,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] retired_cnt
);

  import core_pkg::*;

  // prog_ctr+1 must never wrap before hitting the end address
  if (PROG_LEN >= (2 ** D)) begin : g_prog_len_check
    $error("pc_sequencer: PROG_LEN must be below 2**D");
  end

  localparam logic [D-1:0] LP_END = D'(PROG_LEN);

  seq_state_t r_state;
  seq_state_t w_state_nxt;

  logic [D-1:0] r_pc;
  logic [D-1:0] w_pc_nxt;
  logic [D-1:0] w_pc_inc;
  logic         r_fault;
  logic         w_fault_nxt;
  logic         r_running;
  logic         r_done;
  logic         w_launch;
  logic         w_retire;

  assign w_pc_inc = r_pc + D'(1);

  // State register plus registered datapath and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_fault   <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_fault   <= w_fault_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == HALTED);
    end
  end

  // Next-state: start launches a run, halt / end address / branch at-or-past end stops it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, HALTED: begin
        if (start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt_req) begin
            w_state_nxt = HALTED;
          end else if (branch) begin
            if (target >= LP_END) begin
              w_state_nxt = HALTED;
            end
          end else if (w_pc_inc == LP_END) begin
            w_state_nxt = HALTED;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs of the FSM: next prog_ctr, fault flag and retire-counter controls
  always_comb begin
    w_pc_nxt    = r_pc;
    w_fault_nxt = r_fault;
    w_launch    = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      IDLE, HALTED: begin
        if (start) begin
          w_launch    = 1'b1;
          w_pc_nxt    = '0;
          w_fault_nxt = 1'b0;
        end
      end
      RUN: begin
        if (!stall) begin
          w_retire = 1'b1;
          if (halt_req) begin
            w_pc_nxt = r_pc;
          end else if (branch) begin
            w_pc_nxt    = target;
            w_fault_nxt = (target > LP_END);
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      default: begin
        w_pc_nxt    = '0;
        w_fault_nxt = 1'b0;
      end
    endcase
  end

  sat_counter #(
    .W(CNT_W)
  ) u_retired (
    .clk  (clk),
    .reset(reset),
    .clr  (w_launch),
    .inc  (w_retire),
    .q    (retired_cnt)
  );

  assign prog_ctr = r_pc;
  assign running  = r_running;
  assign done     = r_done;
  assign fault    = r_fault;

endmodule
